// File: rtl/sched_pkg.sv
// Shared encodings for the dual-issue scheduler: instruction classes, buffer
// states and instruction field positions.
package sched_pkg;

  localparam logic [1:0] CLS_R   = 2'b11;
  localparam logic [1:0] CLS_I   = 2'b10;
  localparam logic [1:0] CLS_J   = 2'b01;
  localparam logic [1:0] CLS_ILL = 2'b00;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HALF  = 2'd2
  } state_e;

  localparam int unsigned OP_LO = 12;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RA_LO = 9;
  localparam int unsigned RB_LO = 6;
  localparam int unsigned RC_LO = 3;

  function automatic logic [1:0] op_class(input logic [OP_W-1:0] op);
    logic [1:0] cls;
    casez (op)
      4'b0001, 4'b0010:                            cls = CLS_R;
      4'b0000, 4'b0100, 4'b0101, 4'b1000, 4'b1010: cls = CLS_I;
      4'b0011, 4'b1001, 4'b1011, 4'b11??:          cls = CLS_J;
      default:                                     cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/slot_classify.sv
// Combinational decode of one instruction slot: class plus the register
// specifiers it reads and writes.
module slot_classify
  import sched_pkg::*;
#(
  parameter int unsigned IW   = 16,
  parameter int unsigned REGW = 3
) (
  input  logic [IW-1:0]   instr,
  output logic [1:0]      cls,
  output logic [REGW-1:0] src1,
  output logic            src1_v,
  output logic [REGW-1:0] src2,
  output logic            src2_v,
  output logic [REGW-1:0] dst,
  output logic            dst_v
);

  logic [REGW-1:0] ra, rb, rc;
  logic            unused_low;

  assign ra = instr[RA_LO +: REGW];
  assign rb = instr[RB_LO +: REGW];
  assign rc = instr[RC_LO +: REGW];
  assign unused_low = ^instr[RC_LO-1:0];

  always_comb begin
    cls    = op_class(instr[OP_LO +: OP_W]);
    src1   = '0;
    src1_v = 1'b0;
    src2   = '0;
    src2_v = 1'b0;
    dst    = '0;
    dst_v  = 1'b0;
    unique case (cls)
      CLS_R: begin
        src1 = ra; src1_v = 1'b1;
        src2 = rb; src2_v = 1'b1;
        dst  = rc; dst_v  = 1'b1;
      end
      CLS_I: begin
        src1 = rb; src1_v = 1'b1;
        dst  = ra; dst_v  = 1'b1;
      end
      CLS_J: begin
        src1 = ra; src1_v = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dual_issue_sched.sv
// Two-slot issue scheduler: holds one fetch bundle and issues it whole or split
// in order. Optional perf counters enabled by DUAL_ISSUE_PERF_EN.
module dual_issue_sched
  import sched_pkg::*;
#(
  parameter int unsigned IW   = 16,
  parameter int unsigned REGW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [2*IW-1:0] in_bundle,
  output logic          in_ready,
  input  logic          iss_ready,
  output logic          iss0_valid,
  output logic [IW-1:0] iss0_instr,
  output logic [1:0]    iss0_class,
  output logic          iss1_valid,
  output logic [IW-1:0] iss1_instr,
  output logic [1:0]    iss1_class
`ifdef DUAL_ISSUE_PERF_EN
  ,
  output logic [15:0]   perf_issued,
  output logic [15:0]   perf_split
`endif
);

  state_e            state_q, state_d;
  logic [2*IW-1:0]   bundle_q;
  logic [IW-1:0]     slot_a, slot_b;

  logic [1:0]        a_cls, b_cls;
  logic [REGW-1:0]   a_src1, a_src2, a_dst, b_src1, b_src2, b_dst;
  logic              a_src1_v, a_src2_v, a_dst_v, b_src1_v, b_src2_v, b_dst_v;
  logic              unused_sigs;

  logic              raw, split, kill, issue_fire, empties, accept;

  assign slot_a = bundle_q[2*IW-1:IW];
  assign slot_b = bundle_q[IW-1:0];

  slot_classify #(.IW(IW), .REGW(REGW)) u_cls_a (
    .instr  (slot_a),
    .cls    (a_cls),
    .src1   (a_src1),
    .src1_v (a_src1_v),
    .src2   (a_src2),
    .src2_v (a_src2_v),
    .dst    (a_dst),
    .dst_v  (a_dst_v)
  );

  slot_classify #(.IW(IW), .REGW(REGW)) u_cls_b (
    .instr  (slot_b),
    .cls    (b_cls),
    .src1   (b_src1),
    .src1_v (b_src1_v),
    .src2   (b_src2),
    .src2_v (b_src2_v),
    .dst    (b_dst),
    .dst_v  (b_dst_v)
  );

  // Older slot's sources and younger slot's destination never affect pairing.
  assign unused_sigs = ^{a_src1, a_src1_v, a_src2, a_src2_v, b_dst, b_dst_v};

  assign raw = a_dst_v & ((b_src1_v & (b_src1 == a_dst)) | (b_src2_v & (b_src2 == a_dst)));
  assign split = raw | (a_cls == CLS_J) | (b_cls == CLS_J);

  assign kill       = reset | flush;
  assign issue_fire = (state_q != EMPTY) & iss_ready & ~kill;
  assign empties    = ((state_q == FULL) & ~split) | (state_q == HALF);
  assign in_ready   = ~kill & ((state_q == EMPTY) | (iss_ready & empties));
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    if (issue_fire) begin
      state_d = ((state_q == FULL) && split) ? HALF : EMPTY;
    end
    if (accept) begin
      state_d = FULL;
    end
    if (kill) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      bundle_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bundle_q <= in_bundle;
      end
    end
  end

  // Outputs are masked during reset/flush so nothing is consumed that cycle.
  always_comb begin
    iss0_valid = 1'b0;
    iss0_instr = '0;
    iss0_class = CLS_ILL;
    iss1_valid = 1'b0;
    iss1_instr = '0;
    iss1_class = CLS_ILL;
    if (!kill) begin
      unique case (state_q)
        FULL: begin
          iss0_valid = 1'b1;
          iss0_instr = slot_a;
          iss0_class = a_cls;
          if (!split) begin
            iss1_valid = 1'b1;
            iss1_instr = slot_b;
            iss1_class = b_cls;
          end
        end
        HALF: begin
          iss0_valid = 1'b1;
          iss0_instr = slot_b;
          iss0_class = b_cls;
        end
        default: ;
      endcase
    end
  end

`ifdef DUAL_ISSUE_PERF_EN
  logic [15:0] perf_issued_q, perf_split_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_split_q  <= '0;
    end else if (issue_fire) begin
      perf_issued_q <= perf_issued_q + (iss1_valid ? 16'd2 : 16'd1);
      if ((state_q == FULL) && split) begin
        perf_split_q <= perf_split_q + 16'd1;
      end
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_split  = perf_split_q;
`endif

endmodule

// File: tb/tb_dual_issue_sched.sv
// Scoreboard bench for dual_issue_sched: directed cases followed by random
// traffic, checked against a register-mask reference model.
module tb_dual_issue_sched;

  typedef struct {
    logic        v1;
    logic [15:0] i0;
    logic [1:0]  c0;
    logic [15:0] i1;
    logic [1:0]  c1;
    logic        first_split;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, iss_ready;
  logic [31:0] in_bundle;
  logic        iss0_valid, iss1_valid;
  logic [15:0] iss0_instr, iss1_instr;
  logic [1:0]  iss0_class, iss1_class;
`ifdef DUAL_ISSUE_PERF_EN
  logic [15:0] perf_issued, perf_split;
`endif

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned m_issued = 0;
  int unsigned m_split = 0;

  dual_issue_sched dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_bundle  (in_bundle),
    .in_ready   (in_ready),
    .iss_ready  (iss_ready),
    .iss0_valid (iss0_valid),
    .iss0_instr (iss0_instr),
    .iss0_class (iss0_class),
    .iss1_valid (iss1_valid),
    .iss1_instr (iss1_instr),
    .iss1_class (iss1_class)
`ifdef DUAL_ISSUE_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_split (perf_split)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: classes from the opcode table, register use as bit masks.
  function automatic logic [1:0] m_cls(input logic [15:0] i);
    int op;
    op = int'(i[15:12]);
    if (op == 1 || op == 2) return 2'b11;
    if (op == 0 || op == 4 || op == 5 || op == 8 || op == 10) return 2'b10;
    if (op == 3 || op == 9 || op == 11 || op >= 12) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [7:0] m_src(input logic [15:0] i);
    int ra, rb;
    ra = int'(i[11:9]);
    rb = int'(i[8:6]);
    case (m_cls(i))
      2'b11:   return (8'd1 << ra) | (8'd1 << rb);
      2'b10:   return 8'd1 << rb;
      2'b01:   return 8'd1 << ra;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] m_dst(input logic [15:0] i);
    int ra, rc;
    ra = int'(i[11:9]);
    rc = int'(i[5:3]);
    case (m_cls(i))
      2'b11:   return 8'd1 << rc;
      2'b10:   return 8'd1 << ra;
      default: return 8'd0;
    endcase
  endfunction

  task automatic model_push(input logic [31:0] b);
    logic [15:0] a, y;
    exp_t        e;
    bit          sp;
    a  = b[31:16];
    y  = b[15:0];
    sp = ((m_dst(a) & m_src(y)) != 8'd0) || m_cls(a) == 2'b01 || m_cls(y) == 2'b01;
    if (!sp) begin
      e = '{v1: 1'b1, i0: a, c0: m_cls(a), i1: y, c1: m_cls(y), first_split: 1'b0};
      q.push_back(e);
    end else begin
      e = '{v1: 1'b0, i0: a, c0: m_cls(a), i1: 16'h0, c1: 2'b00, first_split: 1'b1};
      q.push_back(e);
      e = '{v1: 1'b0, i0: y, c0: m_cls(y), i1: 16'h0, c1: 2'b00, first_split: 1'b0};
      q.push_back(e);
    end
  endtask

  // Monitor: inputs are stable at the falling edge; check and retire issues.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      chk("kill_v0", {31'd0, iss0_valid}, 32'd0);
      chk("kill_v1", {31'd0, iss1_valid}, 32'd0);
      chk("kill_instr", {iss0_instr, iss1_instr}, 32'd0);
      chk("kill_class", {28'd0, iss0_class, iss1_class}, 32'd0);
      chk("kill_in_ready", {31'd0, in_ready}, 32'd0);
    end else if (q.size() == 0) begin
      chk("idle_valid", {30'd0, iss0_valid, iss1_valid}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      e = q[0];
      chk("iss0_valid", {31'd0, iss0_valid}, 32'd1);
      chk("iss0", {14'd0, iss0_class, iss0_instr}, {14'd0, e.c0, e.i0});
      chk("iss1_valid", {31'd0, iss1_valid}, {31'd0, e.v1});
      if (e.v1) chk("iss1", {14'd0, iss1_class, iss1_instr}, {14'd0, e.c1, e.i1});
      chk("in_ready", {31'd0, in_ready}, {31'd0, iss_ready && q.size() == 1});
      if (iss_ready) begin
        void'(q.pop_front());
        m_issued = (m_issued + (e.v1 ? 2 : 1)) % 65536;
        if (e.first_split) m_split = (m_split + 1) % 65536;
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] b, input logic ir, input logic fl,
                      input logic rs);
    bit acc;
    bit kl;
    in_valid  = v;
    in_bundle = b;
    iss_ready = ir;
    flush     = fl;
    reset     = rs;
    @(negedge clk);
    acc = v && in_ready;
    kl  = fl || rs;
    @(posedge clk);
    #1;
    if (kl) q.delete();
    else if (acc) model_push(b);
    if (rs) begin
      m_issued = 0;
      m_split  = 0;
    end
  endtask

  task automatic chk_perf(input string name);
`ifdef DUAL_ISSUE_PERF_EN
    chk({name, "_issued"}, {16'd0, perf_issued}, m_issued);
    chk({name, "_split"}, {16'd0, perf_split}, m_split);
`else
    chk({name, "_drained"}, q.size(), 32'd0);
`endif
  endtask

  initial begin
    in_valid = 1'b0; in_bundle = '0; iss_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0);

    // Independent pair, RAW split, J in slot B
    step(1, 32'h1298_1970, 1, 0, 0);
    step(1, 32'h1298_1660, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(1, 32'h1298_C000, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Backpressure then release with back-to-back load
    step(1, 32'h1298_1970, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h0123_4567, 0, 0, 0);
    step(1, 32'h0123_4567, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Flush in HALF drops the younger instruction
    step(1, 32'h1298_1660, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 1, 0);
    step(0, 32'h0, 1, 0, 0);
    chk_perf("perf_mid");

    // Illegal slot A, then reset during a hold
    step(1, 32'h6000_1970, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 1, 0, 0);
    chk_perf("perf_reset");

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(3, 0) != 0, $urandom, $urandom_range(3, 0) != 0,
           $urandom_range(31, 0) == 0, $urandom_range(99, 0) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);
    chk("drain_empty", q.size(), 32'd0);
    chk_perf("perf_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_sched.md
Name: dual_issue_sched

Overview:
- Issue scheduler between fetch and the two execution ports of the 2-wide core.
- Accepts one 32-bit bundle per handshake, holding two 16-bit instructions: slot A = bits [31:16] (older), slot B = bits [15:0] (younger).
- Classifies each instruction as R/I/J and checks the intra-bundle RAW dependency and the branch-unit constraint.
- Issues both instructions in one cycle when legal; otherwise splits the bundle over two cycles, in order.

Parameters:
- IW, 16, instruction width per slot.
- REGW, 3, register-specifier width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous pipeline flush; discards held bundle.
- in_valid  in  1  fetch bundle valid.
- in_bundle  in  32  {slot A, slot B}.
- in_ready  out  1  scheduler can accept the bundle this cycle.
- iss_ready  in  1  execution stage accepts every valid issue output this cycle.
- iss0_valid  out  1  port 0 (ALU + branch unit) valid.
- iss0_instr  out  16  port 0 instruction.
- iss0_class  out  2  11=R, 10=I, 01=J, 00=illegal.
- iss1_valid  out  1  port 1 (ALU only) valid.
- iss1_instr  out  16  port 1 instruction.
- iss1_class  out  2  same encoding as iss0_class.

Behaviour:
- Classification, op = instr[15:12]:
  - R: 0001, 0010.
  - I: 0000, 0100, 0101, 1000, 1010.
  - J: 0011, 1001, 1011, 11xx.
  - Illegal: 0110, 0111.
- Register fields: RA=[11:9], RB=[8:6], RC=[5:3].
  - R: sources RA, RB; destination RC.
  - I: source RB; destination RA.
  - J: source RA; no destination.
  - Illegal: no sources, no destination.
- Split condition, evaluated on the held bundle:
  - RAW: A has a destination, and that destination equals any source of B.
  - B is J (the branch unit exists only on port 0).
  - A is J (B must not issue alongside a control transfer).
- States:
  - EMPTY: nothing held.
  - FULL: A and B both pending.
  - HALF: only B pending.
- Transitions:
  - EMPTY, in_valid&in_ready -> FULL.
  - FULL, iss_ready, no split -> EMPTY.
  - FULL, iss_ready, split -> HALF.
  - FULL, !iss_ready -> FULL (hold).
  - HALF, iss_ready -> EMPTY.
  - HALF, !iss_ready -> HALF (hold).
- Issue outputs are driven from the held bundle:
  - FULL, no split: iss0 = A, iss1 = B, both valid.
  - FULL, split: iss0 = A only; iss1_valid = 0.
  - HALF: iss0 = B; iss1_valid = 0.
- Outputs are stable while valid and !iss_ready.
- in_ready = (state==EMPTY) | (iss_ready & the current issue empties the buffer) & !flush.
  - Back-to-back: a new bundle loads in the same cycle the last pending instruction issues.
  - Latency: bundle accepted in cycle N appears on iss0/iss1 in cycle N+1.
  - Sustained throughput: one bundle per cycle when nothing splits.
- Illegal instructions are issued with class 00 (the execute stage traps). An illegal instruction never causes a split.
- reset or flush:
  - Next state EMPTY.
  - iss0_valid = iss1_valid = 0.
  - iss*_instr = 0, iss*_class = 00.
  - in_ready = 0 in the flush/reset cycle.
- reset has priority over flush. flush has priority over a simultaneous accept or issue: neither takes effect.
- Flush in HALF discards B.

Optional Feature:
- Macro: DUAL_ISSUE_PERF_EN.
- When defined, adds outputs perf_issued (16 bits: instructions issued, +1 or +2 per issuing cycle) and perf_split (16 bits: bundles that split).
  - Both counters wrap at 0xFFFF -> 0.
  - Both are cleared by reset only, not by flush.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package sched_pkg:
  - class encoding constants CLS_R/CLS_I/CLS_J/CLS_ILL.
  - state enum {EMPTY, FULL, HALF}.
  - field-position constants.
- Sub-module slot_classify (combinational, one instance per slot): outputs class, src1/src1_v, src2/src2_v, dst/dst_v.
- Split logic and FSM stay in the top level.

Test Plan:
- Independent pair: bundle 0x1298_1970, iss_ready=1 -> next cycle iss0=0x1298 class 11, iss1=0x1970 class 11, both valid, in_ready=1.
- RAW split: bundle 0x1298_1660 (A writes R3; B reads R3) -> cycle 1: iss0=0x1298 only. Cycle 2: iss0=0x1660, iss1_valid=0.
- J in slot B: bundle 0x1298_C000 -> split; cycle 2 iss0=0xC000 class 01.
- Backpressure: iss_ready=0 for 3 cycles on bundle 0x1298_1970 -> outputs held constant, in_ready=0. Release -> issue, with a new bundle accepted the same cycle.
- Flush in HALF: flush=1 after the first half of 0x1298_1660 -> next cycle both valids 0, state EMPTY, 0x1660 never issued.
- Illegal plus reset: bundle 0x6000_1970 -> both issue, iss0_class=00. Assert reset mid-hold -> all outputs 0 next cycle; with DUAL_ISSUE_PERF_EN, counters read 0.
